// File: rtl/rvm_muldiv_if.sv
// Operation bus for the iterative multiply/divide unit: request side driven by
// the core control FSM, busy/valid/result driven back by the unit.
interface rvm_muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      op;
  logic [XLEN-1:0] lhs;
  logic [XLEN-1:0] rhs;
  logic            busy;
  logic            valid;
  logic [XLEN-1:0] result;

  // Handshake: start is taken only while busy=0 and flush=0; busy stays high
  // until the valid cycle ends; valid pulses once per accepted operation and
  // never follows a flush; result holds from valid until the next acceptance.
  modport master (
    output start, flush, op, lhs, rhs,
    input  busy, valid, result
  );

  modport slave (
    input  start, flush, op, lhs, rhs,
    output busy, valid, result
  );
endinterface

// File: rtl/rvm_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply and restoring
// divide on operand magnitudes, STEPS iterations per clock, sign fix-up at end.
module rvm_muldiv #(
  parameter int XLEN  = 32,
  parameter int STEPS = 1
) (
  input  logic            clk,
  input  logic            reset,
  rvm_muldiv_if.slave     bus,
  output logic [1:0]      dbg_state
);
  localparam int ITERS = XLEN / STEPS;
  localparam int CW    = $clog2(ITERS) + 1;
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     count;
  logic [2*XLEN-1:0] acc, acc_nx, prod_fix;
  logic [XLEN-1:0]   opb, result_q, fix_word;
  logic [2:0]        op_q;
  logic              neg_q;

  // Acceptance decode on the live request
  logic            is_div, lhs_sgn, rhs_sgn, sa, sb, div_zero, div_ovf, special, neg_in;
  logic [XLEN-1:0] mag_a, mag_b, special_res;

  always_comb begin
    is_div   = bus.op[2];
    lhs_sgn  = (bus.op == 3'd1) || (bus.op == 3'd2) || (bus.op == 3'd4) || (bus.op == 3'd6);
    rhs_sgn  = (bus.op == 3'd1) || (bus.op == 3'd4) || (bus.op == 3'd6);
    sa       = lhs_sgn & bus.lhs[XLEN-1];
    sb       = rhs_sgn & bus.rhs[XLEN-1];
    mag_a    = sa ? -bus.lhs : bus.lhs;
    mag_b    = sb ? -bus.rhs : bus.rhs;
    div_zero = is_div && (bus.rhs == '0);
    div_ovf  = is_div && !bus.op[0] && (bus.lhs == MIN_INT) && (bus.rhs == '1);
    special  = div_zero || div_ovf;
    // Remainder follows the dividend's sign; products and quotients use the xor.
    neg_in   = (is_div && bus.op[1]) ? sa : (sa ^ sb);
    if (div_zero) special_res = bus.op[1] ? bus.lhs : '1;
    else          special_res = bus.op[1] ? '0 : bus.lhs;
  end

  // STEPS iterations per clock. Multiply keeps the multiplier in the low half and
  // accumulates into the high half; divide keeps {remainder, quotient}.
  logic [XLEN:0]   sum, rem_shift;
  logic [XLEN-1:0] diff;

  always_comb begin
    acc_nx    = acc;
    sum       = '0;
    rem_shift = '0;
    diff      = '0;
    for (int s = 0; s < STEPS; s++) begin
      if (op_q[2]) begin
        rem_shift = {acc_nx[2*XLEN-1:XLEN], acc_nx[XLEN-1]};
        diff      = rem_shift[XLEN-1:0] - opb;
        if (rem_shift >= {1'b0, opb}) acc_nx = {diff, acc_nx[XLEN-2:0], 1'b1};
        else                          acc_nx = {acc_nx[2*XLEN-2:0], 1'b0};
      end else begin
        sum    = {1'b0, acc_nx[2*XLEN-1:XLEN]} + (acc_nx[0] ? {1'b0, opb} : '0);
        acc_nx = {sum, acc_nx[XLEN-1:1]};
      end
    end
  end

  // The product is negated as a full double word before the high half is taken.
  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    case (op_q)
      3'd0:                fix_word = prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    fix_word = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:          fix_word = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      default:             fix_word = neg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (bus.flush) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.start) state_nx = special ? DONE : CALC;
        CALC:    if (count == CW'(1)) state_nx = FIX;
        FIX:     state_nx = DONE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.busy   = (state != IDLE);
    bus.valid  = (state == DONE) && !bus.flush;
    bus.result = result_q;
    dbg_state  = state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      acc      <= '0;
      opb      <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else if (!bus.flush) begin
      case (state)
        IDLE: if (bus.start) begin
          op_q  <= bus.op;
          neg_q <= neg_in;
          count <= CW'(ITERS);
          if (is_div) begin
            acc <= {{XLEN{1'b0}}, mag_a};
            opb <= mag_b;
          end else begin
            acc <= {{XLEN{1'b0}}, mag_b};
            opb <= mag_a;
          end
          if (special) result_q <= special_res;
        end
        CALC: begin
          acc   <= acc_nx;
          count <= count - 1'b1;
        end
        FIX:     result_q <= fix_word;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rvm_muldiv.sv
// Bench for rvm_muldiv: a 32-bit/1-step and a 64-bit/4-step instance on one clock,
// scoreboard queues of expected results checked against each valid pulse.
module tb_rvm_muldiv;
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg32, dbg64;

  always #5 clk = ~clk;

  rvm_muldiv_if #(.XLEN(32)) bus32();
  rvm_muldiv_if #(.XLEN(64)) bus64();

  rvm_muldiv #(.XLEN(32), .STEPS(1)) dut32 (.clk(clk), .reset(reset), .bus(bus32), .dbg_state(dbg32));
  rvm_muldiv #(.XLEN(64), .STEPS(4)) dut64 (.clk(clk), .reset(reset), .bus(bus64), .dbg_state(dbg64));

  logic [31:0] exp_q[$];
  logic [63:0] exp64_q[$];
  logic [31:0] last_res32;
  int          n_cmp = 0;
  int          n_err = 0;

  localparam logic [31:0] MIN32 = 32'h8000_0000;

  // Reference results straight from SystemVerilog wide arithmetic.
  function automatic logic [31:0] model32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    logic        [63:0] up;
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (op)
      3'd0: begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
      3'd1: begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return sp[63:32]; end
      3'd2: begin sp = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return sp[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN32 && b == 32'hFFFF_FFFF) return a;
        return sa / sb;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN32 && b == 32'hFFFF_FFFF) return 32'h0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic drive_idle();
    bus32.start = 0; bus32.flush = 0; bus32.op = 0; bus32.lhs = 0; bus32.rhs = 0;
    bus64.start = 0; bus64.flush = 0; bus64.op = 0; bus64.lhs = 0; bus64.rhs = 0;
  endtask

  // One 32-bit operation; optionally re-pulses start with junk operands mid-flight.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_val,
                        input int exp_lat, input int repulse_at);
    int cyc, bcnt, vcyc;
    logic [31:0] exp_r;
    @(negedge clk);
    bus32.op = op; bus32.lhs = a; bus32.rhs = b; bus32.start = 1;
    exp_q.push_back(exp_val);
    @(posedge clk); #1;
    bus32.start = 0;
    bus32.op  = 3'($urandom_range(0, 7));
    bus32.lhs = $urandom;
    bus32.rhs = $urandom;
    cyc = 0; bcnt = 0; vcyc = 0;
    while (vcyc == 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus32.busy) bcnt++;
      if (bus32.valid) vcyc = cyc;
      if (cyc == repulse_at) begin
        bus32.start = 1; bus32.lhs = $urandom; bus32.rhs = $urandom;
      end else begin
        bus32.start = 0;
      end
    end
    exp_r = exp_q.pop_front();
    n_cmp++;
    if (vcyc != exp_lat) begin
      n_err++;
      $display("FAIL %s latency: got cycle %0d, want %0d", name, vcyc, exp_lat);
    end
    n_cmp++;
    if (bus32.result !== exp_r) begin
      n_err++;
      $display("FAIL %s result: got %h, want %h", name, bus32.result, exp_r);
    end
    n_cmp++;
    if (bcnt != exp_lat) begin
      n_err++;
      $display("FAIL %s busy_cycles: got %0d, want %0d", name, bcnt, exp_lat);
    end
    @(negedge clk);
    n_cmp++;
    if (bus32.valid !== 1'b0 || bus32.busy !== 1'b0 || bus32.result !== exp_r) begin
      n_err++;
      $display("FAIL %s after_done: valid=%b busy=%b result=%h, want 0 0 %h",
               name, bus32.valid, bus32.busy, bus32.result, exp_r);
    end
    last_res32 = exp_r;
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1;
    @(negedge clk);
    n_cmp++;
    if (bus32.busy !== 0 || bus32.valid !== 0 || bus32.result !== 32'h0 || dbg32 !== 2'd0) begin
      n_err++;
      $display("FAIL reset32: busy=%b valid=%b result=%h state=%0d, want 0 0 0 0",
               bus32.busy, bus32.valid, bus32.result, dbg32);
    end
    n_cmp++;
    if (bus64.busy !== 0 || bus64.valid !== 0 || bus64.result !== 64'h0) begin
      n_err++;
      $display("FAIL reset64: busy=%b valid=%b result=%h, want 0 0 0", bus64.busy, bus64.valid, bus64.result);
    end
    reset = 0;
    last_res32 = 0;
  endtask

  task automatic test_mul();
    run_op("mul_7x-3",   3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 0);
    run_op("mulh_min",   3'd1, MIN32,        MIN32,         32'h4000_0000, 34, 0);
    run_op("mulhu_max",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 0);
    run_op("mulhsu_m1",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 0);
    run_op("mul_zero",   3'd0, 32'd0,        32'd12345,     32'd0,         34, 0);
  endtask

  task automatic test_div();
    run_op("div_-7_2",   3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 0);
    run_op("rem_-7_2",   3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0);
    run_op("divu_100_7", 3'd5, 32'd100,       32'd7, 32'd14,        34, 0);
    run_op("remu_100_7", 3'd7, 32'd100,       32'd7, 32'd2,         34, 0);
  endtask

  task automatic test_div_special();
    run_op("div_by0",  3'd4, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1, 0);
    run_op("divu_by0", 3'd5, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1, 0);
    run_op("rem_by0",  3'd6, 32'h1234_5678, 32'd0, 32'h1234_5678, 1, 0);
    run_op("remu_by0", 3'd7, 32'h1234_5678, 32'd0, 32'h1234_5678, 1, 0);
    run_op("div_ovf",  3'd4, MIN32, 32'hFFFF_FFFF, MIN32, 1, 0);
    run_op("rem_ovf",  3'd6, MIN32, 32'hFFFF_FFFF, 32'h0, 1, 0);
  endtask

  task automatic test_random();
    logic [31:0] vals [6];
    logic [2:0]  op;
    logic [31:0] a, b;
    int          lat;
    vals = '{32'h0, 32'h1, 32'hFFFF_FFFF, MIN32, 32'h7FFF_FFFF, 32'h3};
    for (int i = 0; i < 16; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 2) == 0) ? vals[$urandom_range(0, 5)] : $urandom;
      b  = ($urandom_range(0, 2) == 0) ? vals[$urandom_range(0, 5)] : $urandom;
      lat = (op[2] && (b == 0 || (!op[0] && a == MIN32 && b == 32'hFFFF_FFFF))) ? 1 : 34;
      run_op("random", op, a, b, model32(op, a, b), lat, 0);
    end
  endtask

  task automatic test_start_ignored();
    run_op("start_ignored", 3'd5, 32'd1000, 32'd9, 32'd111, 34, 5);
  endtask

  task automatic test_flush();
    logic [31:0] prev;
    int          seen;
    prev = last_res32;
    // flush and start together in IDLE: nothing accepted
    @(negedge clk);
    bus32.op = 3'd5; bus32.lhs = 32'd1000; bus32.rhs = 32'd3; bus32.start = 1; bus32.flush = 1;
    @(posedge clk); #1;
    bus32.start = 0; bus32.flush = 0;
    @(negedge clk);
    n_cmp++;
    if (bus32.busy !== 1'b0) begin
      n_err++;
      $display("FAIL flush_start_idle busy: got %b, want 0", bus32.busy);
    end
    // flush mid-CALC
    bus32.start = 1;
    @(posedge clk); #1;
    bus32.start = 0;
    for (int c = 1; c <= 10; c++) @(negedge clk);
    bus32.flush = 1;
    #1;
    n_cmp++;
    if (bus32.valid !== 1'b0 || bus32.busy !== 1'b1) begin
      n_err++;
      $display("FAIL flush_cycle: valid=%b busy=%b, want 0 1", bus32.valid, bus32.busy);
    end
    @(posedge clk); #1;
    bus32.flush = 0;
    @(negedge clk);
    n_cmp++;
    if (bus32.busy !== 1'b0) begin
      n_err++;
      $display("FAIL flush_busy_drop: got %b, want 0", bus32.busy);
    end
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus32.valid || bus32.busy) seen++;
    end
    n_cmp++;
    if (seen != 0 || bus32.result !== prev) begin
      n_err++;
      $display("FAIL flush_after: activity=%0d result=%h, want 0 %h", seen, bus32.result, prev);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    bus32.op = 3'd0; bus32.lhs = 32'd99; bus32.rhs = 32'd77; bus32.start = 1;
    @(posedge clk); #1;
    bus32.start = 0;
    for (int c = 0; c < 5; c++) @(negedge clk);
    reset = 1;
    #1;
    n_cmp++;
    if (bus32.busy !== 0 || bus32.valid !== 0 || bus32.result !== 32'h0 || dbg32 !== 2'd0) begin
      n_err++;
      $display("FAIL reset_mid: busy=%b valid=%b result=%h state=%0d, want 0 0 0 0",
               bus32.busy, bus32.valid, bus32.result, dbg32);
    end
    @(negedge clk);
    reset = 0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus32.valid || bus32.busy) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL reset_mid_after: activity cycles=%0d, want 0", seen);
    end
    last_res32 = 0;
  endtask

  task automatic test_back_to_back();
    int v1, v2, busy19, busy20, cnt_valid;
    logic [63:0] exp_r;
    @(negedge clk);
    bus64.op = 3'd0; bus64.lhs = 64'hFFFF_FFFF_FFFF_FFFF; bus64.rhs = 64'd2; bus64.start = 1;
    exp64_q.push_back(64'hFFFF_FFFF_FFFF_FFFE);
    @(posedge clk); #1;
    // start stays high; the second operation's operands are presented now
    bus64.lhs = 64'h1234_5678_9ABC_DEF0; bus64.rhs = 64'h10;
    exp64_q.push_back(64'h2345_6789_ABCD_EF00);
    v1 = 0; v2 = 0; busy19 = -1; busy20 = -1; cnt_valid = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (cyc == 19) busy19 = int'(bus64.busy);
      if (cyc == 20) begin busy20 = int'(bus64.busy); bus64.start = 0; end
      if (bus64.valid) begin
        cnt_valid++;
        if (v1 == 0) v1 = cyc; else v2 = cyc;
        exp_r = (exp64_q.size() != 0) ? exp64_q.pop_front() : 64'hX;
        n_cmp++;
        if (bus64.result !== exp_r) begin
          n_err++;
          $display("FAIL wide_result #%0d: got %h, want %h", cnt_valid, bus64.result, exp_r);
        end
      end
    end
    n_cmp++;
    if (v1 != 18 || v2 != 37 || cnt_valid != 2) begin
      n_err++;
      $display("FAIL wide_latency: valid cycles %0d,%0d count %0d, want 18,37 count 2", v1, v2, cnt_valid);
    end
    n_cmp++;
    if (busy19 != 0 || busy20 != 1) begin
      n_err++;
      $display("FAIL back_to_back_accept: busy@19=%0d busy@20=%0d, want 0 1", busy19, busy20);
    end
    n_cmp++;
    if (exp64_q.size() != 0) begin
      n_err++;
      $display("FAIL wide_queue: %0d results outstanding, want 0", exp64_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_special();
    test_random();
    test_start_ignored();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d results outstanding, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
